// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared types and constants for the operand forwarding / hazard controller.
// Sizes here describe the default 5-bit register file and two producer stages.
package fwd_hazard_ctrl_pkg;

  localparam int REGW_DEF = 5;
  localparam int NSTG_DEF = 2;

  typedef logic [REGW_DEF-1:0] regbits_t;

  // Width of a forwarding select able to name the register file or any of nstg stages.
  function automatic int sel_width(input int nstg);
    return (nstg < 1) ? 1 : $clog2(nstg + 1);
  endfunction

  localparam int SELW_DEF = sel_width(NSTG_DEF);

  typedef logic [SELW_DEF-1:0] fwsel_t;

  localparam fwsel_t FW_REGFILE = '0;

endpackage

// File: rtl/fwd_hazard_ctrl_mc_scoreboard.sv
// Countdown scoreboard for in-flight multi-cycle writers (mult/div).
// Each entry stays valid for exactly MC_LAT cycles after its start cycle.
module fwd_hazard_ctrl_mc_scoreboard
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int NSRC    = 2,
  parameter int REGW    = 5,
  parameter int MAXPEND = 2,
  parameter int MC_LAT  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mc_start,
  input  logic [REGW-1:0]      mc_wsel,
  input  logic                 mc_kill,
  input  logic [NSRC*REGW-1:0] src_reg,
  input  logic [NSRC-1:0]      src_used,
  output logic [NSRC-1:0]      busy,
  output logic                 pend_full,
  output logic                 sb_err
);

  localparam int CW = $clog2(MC_LAT + 1);

  logic [MAXPEND-1:0] valid_q;
  logic [REGW-1:0]    wsel_q [MAXPEND];
  logic [CW-1:0]      cnt_q  [MAXPEND];
  logic               err_q;

  logic [MAXPEND-1:0] alloc_oh;
  logic               alloc_found;
  logic [REGW-1:0]    src;

  assign pend_full = &valid_q;
  assign sb_err    = err_q;

  always_comb begin
    alloc_oh    = '0;
    alloc_found = 1'b0;
    for (int e = 0; e < MAXPEND; e++) begin
      if (!valid_q[e] && !alloc_found) begin
        alloc_oh[e] = 1'b1;
        alloc_found = 1'b1;
      end
    end
  end

  // Busy also covers an op launching this very cycle so its consumer cannot slip past.
  always_comb begin
    busy = '0;
    src  = '0;
    for (int i = 0; i < NSRC; i++) begin
      src = src_reg[i*REGW +: REGW];
      if (src_used[i] && (src != '0)) begin
        for (int e = 0; e < MAXPEND; e++) begin
          if (valid_q[e] && (wsel_q[e] == src)) busy[i] = 1'b1;
        end
        if (mc_start && (mc_wsel == src)) busy[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      err_q   <= 1'b0;
      for (int e = 0; e < MAXPEND; e++) begin
        wsel_q[e] <= '0;
        cnt_q[e]  <= '0;
      end
    end else begin
      for (int e = 0; e < MAXPEND; e++) begin
        if (valid_q[e]) begin
          if (cnt_q[e] > CW'(1)) cnt_q[e] <= cnt_q[e] - CW'(1);
          else                   valid_q[e] <= 1'b0;
        end
      end
      // Kill wins over a same-cycle launch; a retiring entry is still counted as full.
      if (mc_kill) begin
        valid_q <= '0;
      end else if (mc_start && (mc_wsel != '0)) begin
        if (pend_full) begin
          err_q <= 1'b1;
        end else begin
          for (int e = 0; e < MAXPEND; e++) begin
            if (alloc_oh[e]) begin
              valid_q[e] <= 1'b1;
              wsel_q[e]  <= mc_wsel;
              cnt_q[e]   <= CW'(MC_LAT);
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding select and stall generation for the EX operand muxes: picks the
// youngest matching producer, flags load-use and multi-cycle hazards, counts stalls.
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int NSRC    = 2,
  parameter int NSTG    = 2,
  parameter int REGW    = 5,
  parameter int MAXPEND = 2,
  parameter int MC_LAT  = 4,
  parameter int CNTW    = 32,
  localparam int SELW   = sel_width(NSTG)
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 issue_valid,
  input  logic [NSRC*REGW-1:0] src_reg,
  input  logic [NSRC-1:0]      src_used,
  input  logic [NSTG-1:0]      stg_wen,
  input  logic [NSTG*REGW-1:0] stg_wsel,
  input  logic [NSTG-1:0]      stg_rdy,
  input  logic                 mc_start,
  input  logic [REGW-1:0]      mc_wsel,
  input  logic                 mc_kill,
  output logic [NSRC*SELW-1:0] fw_sel,
  output logic                 stall,
  output logic                 pend_full,
  output logic                 sb_err,
  output logic [CNTW-1:0]      stall_cnt
);

  logic [NSRC-1:0] mc_busy;
  logic [NSRC-1:0] hazard;
  logic [REGW-1:0] src;
  logic [SELW-1:0] sel;
  logic            found;
  logic [CNTW-1:0] cnt_q;

  fwd_hazard_ctrl_mc_scoreboard #(
    .NSRC    (NSRC),
    .REGW    (REGW),
    .MAXPEND (MAXPEND),
    .MC_LAT  (MC_LAT)
  ) u_sb (
    .clk       (CLK),
    .rst_n     (nRST),
    .mc_start  (mc_start),
    .mc_wsel   (mc_wsel),
    .mc_kill   (mc_kill),
    .src_reg   (src_reg),
    .src_used  (src_used),
    .busy      (mc_busy),
    .pend_full (pend_full),
    .sb_err    (sb_err)
  );

  // Only the youngest match is considered; an unready youngest producer never
  // falls through to an older copy of the same register.
  always_comb begin
    fw_sel = '0;
    hazard = '0;
    src    = '0;
    sel    = '0;
    found  = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      src   = src_reg[i*REGW +: REGW];
      sel   = SELW'(FW_REGFILE);
      found = 1'b0;
      for (int k = 0; k < NSTG; k++) begin
        if (!found && src_used[i] && stg_wen[k] &&
            (stg_wsel[k*REGW +: REGW] != '0) &&
            (stg_wsel[k*REGW +: REGW] == src)) begin
          found = 1'b1;
          sel   = SELW'(k + 1);
          if (!stg_rdy[k]) hazard[i] = 1'b1;
        end
      end
      if (mc_busy[i]) hazard[i] = 1'b1;
      fw_sel[i*SELW +: SELW] = sel;
    end
  end

  assign stall     = issue_valid & (|hazard);
  assign stall_cnt = cnt_q;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      cnt_q <= '0;
    end else if (stall && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNTW'(1);
    end
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Parametrised successor to the two-port, two-stage pipeline forwarding logic.
- Generates a forwarding select for each of NSRC source operands, taken from NSTG younger-to-older producer stages.
- Detects load-use hazards through per-stage data-ready flags.
- Tracks in-flight multi-cycle writers (mult/div) in a countdown scoreboard and raises stall until they retire. Also keeps a saturating stall-cycle counter for performance measurement.
- Sits between the ID/EX register and the EX operand muxes; drives the hazard unit's stall input.

Parameters:
- NSRC, 2, number of source operands checked per instruction
- NSTG, 2, number of forwarding producer stages; index 0 = youngest (EX/MEM), highest priority
- REGW, 5, register-select width
- MAXPEND, 2, scoreboard entries for outstanding multi-cycle writes
- MC_LAT, 4, cycles from multi-cycle start to retirement (>=1)
- CNTW, 32, stall counter width

Ports:
- CLK  in  1  clock
- nRST  in  1  synchronous active-low reset
- issue_valid  in  1  ID/EX holds a valid instruction
- src_reg  in  NSRC*REGW  source register selects, operand i at [i*REGW +: REGW]
- src_used  in  NSRC  operand i is actually read (e.g. rt unused for i-type)
- stg_wen  in  NSTG  stage k will write a register
- stg_wsel  in  NSTG*REGW  stage k destination
- stg_rdy  in  NSTG  stage k result already available (0 for a load still in EX/MEM)
- mc_start  in  1  multi-cycle op launched this cycle
- mc_wsel  in  REGW  its destination
- mc_kill  in  1  flush all outstanding multi-cycle entries
- fw_sel  out  NSRC*SELW  SELW=$clog2(NSTG+1); 0 = register file, k+1 = stage k
- stall  out  1  hold ID/EX and earlier stages
- pend_full  out  1  all MAXPEND entries valid
- sb_err  out  1  sticky: mc_start accepted while full
- stall_cnt  out  CNTW  saturating count of stalled valid cycles

Behaviour:
- All decisions combinational from inputs plus registered scoreboard; fw_sel and stall have zero latency.
- Operand i match at stage k: src_used[i] & stg_wen[k] & stg_wsel[k]!=0 & stg_wsel[k]==src_reg[i].
- fw_sel[i] = lowest matching k, plus 1; 0 if no stage matches.
- Register 0 never matches, in stages or in the scoreboard.
- Load-use: if the lowest matching stage has stg_rdy[k]=0, the operand hazards. No fall-through to an older stage.
- MC hazard: operand i hazards if any valid entry has wsel==src_reg[i] (with src_used[i]=1). Also hazards if mc_start=1 with mc_wsel==src_reg[i] this cycle (same-cycle bypass).
- stall = issue_valid & OR of all operand hazards. fw_sel is still reported during stall.
- Scoreboard entry fields: valid, wsel, cnt (clog2(MC_LAT+1) bits).
- Allocation: mc_start & mc_wsel!=0 & !pend_full takes the lowest invalid index, with cnt=MC_LAT.
- Aging: every edge, each valid entry with cnt>1 decrements; an entry with cnt==1 clears valid. An entry is therefore valid for exactly MC_LAT cycles after the start cycle.
- Retiring entries are not free in the cycle they retire.
- mc_start while pend_full: nothing is allocated and sb_err sets (cleared only by reset).
- mc_wsel=0: nothing is allocated and no error.
- Duplicate destinations get separate entries; a consumer stalls until all of them retire.
- mc_kill: all entries invalid at the next edge. Kill beats a simultaneous mc_start (no allocation, no error).
- stall_cnt increments on each edge where stall=1 and saturates at all ones.
- Reset (nRST=0 at the edge) clears all entries, stall_cnt and sb_err, and overrides every other input. After reset with idle inputs: fw_sel=0, stall=0, pend_full=0.

Decomposition:
- Add to cpu_types_pkg: FW_REGFILE=0 constant and a fwsel typedef sized from NSTG.
- Reuse the existing regbits_t for REGW=5.
- Natural sub-module: mc_scoreboard, containing the entry array, allocation, aging, kill, pend_full and sb_err. It exposes a per-operand busy vector for a given src_reg list.
- Match and priority logic stay in the top level.

Test Plan:
- EX/MEM writes r5 (rdy=1), MEM/WB writes r5. src0=r5 gives fw_sel0=1; src1=r5 with src_used1=0 gives fw_sel1=0. stall=0.
- Load to r8 in stage 0 (rdy=0), MEM/WB writes r8 with rdy=1. src0=r8, issue_valid=1 gives stall=1 for that cycle and stall_cnt +1. Next cycle, load moved to stage 1 (rdy=1): fw_sel0=2, stall=0.
- Any stage writes r0 and src0=r0: fw_sel0=0 and stall=0.
- MC_LAT=4: mc_start r9 at cycle 0, consumer src0=r9 held from cycle 0 gives stall high for cycles 0-4 and low at cycle 5. stall_cnt=5.
- MAXPEND=2: start r3 and r4 on consecutive cycles gives pend_full=1. A third start while full sets sb_err=1 and allocates nothing. mc_kill clears pend_full next cycle, with sb_err still 1.
- Assert nRST=0 mid-countdown with stall active. Next cycle: no entries, stall_cnt=0, sb_err=0, stall=0 for an r9 consumer.
